// File: rtl/act_unit_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// act_sched_pkg
//
// Shared constants and types for the activation-unit scheduler:
//   - default fixed-point formats of the activation unit operand/result
//   - default requester count and ID width
//   - GRU requester IDs (update gate Z, reset gate R, candidate state H)
//   - activation mode encoding driven onto act_modeSEL
//   - small helper for round-robin index wrap
// -----------------------------------------------------------------------------
package act_sched_pkg;

  // Operand format into the activation unit: signed WI.WF
  localparam int DEF_WI_IN  = 6;
  localparam int DEF_WF_IN  = 14;

  // Result format out of the activation unit: signed WI.WF
  localparam int DEF_WI_OUT = 8;
  localparam int DEF_WF_OUT = 6;

  // Requester population (legal range 2..8)
  localparam int DEF_N_REQ  = 3;
  localparam int DEF_ID_W   = $clog2(DEF_N_REQ);

  // GRU gate requester IDs
  typedef enum logic [1:0] {
    ID_Z = 2'd0,  // update gate
    ID_R = 2'd1,  // reset gate
    ID_H = 2'd2   // candidate state
  } gru_req_id_e;

  // Activation function select as seen by the unit (ReLU enable overrides)
  typedef enum logic {
    MODE_TANH   = 1'b0,
    MODE_LOGSIG = 1'b1
  } act_mode_e;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : act_sched_pkg

// File: rtl/act_unit_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Round-robin arbiter with a registered priority pointer. The grant is purely
// combinational over req: the search starts at rr_ptr and walks upward with
// wrap, so the most recently served requester has the lowest priority next.
// The pointer moves to (winner + 1) mod N_REQ only when the grant is actually
// consumed (adv high and some request present); otherwise it holds.
//
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   synchronous active-high reset (pointer -> 0)
//   req       in   N_REQ request vector
//   adv       in   downstream can take the winner this cycle
//   grant     out  one-hot grant (all zero when no request)
//   grant_id  out  binary index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter
  import act_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            found;

  // Masked priority search starting at rr_ptr_q.
  // NOTE: every output of a combinational block gets a default assignment
  // before any conditional logic; a path that leaves one unassigned would
  // infer a latch.
  always_comb begin : search
    int              idx;
    logic [ID_W-1:0] idx_l;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    idx_l    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_l = ID_W'(idx);
      if (!found && req[idx_l]) begin
        found        = 1'b1;
        grant[idx_l] = 1'b1;
        grant_id     = idx_l;
      end
    end
  end

  // Pointer only moves when the grant is consumed.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv && found) begin
      rr_ptr_d = ID_W'(wrap_inc(int'(grant_id), N_REQ));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block evaluation order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule : rr_arbiter

// File: rtl/act_unit_scheduler.sv
// -----------------------------------------------------------------------------
// act_unit_scheduler
//
// Shares one external combinational piecewise-linear activation unit
// (logsig / tanh / ReLU) among the GRU gate requesters. Two register stages:
//   S1: selected operand, mode and ReLU enable presented to the unit
//       (act_x / act_modeSEL / act_ReLU_EN) plus the requester tag.
//   S2: unit result captured with its requester tag (rsp_y / rsp_id).
// Both stages are elastic: a full pipeline sustains one op per cycle and
// downstream back-pressure stalls S2 and, when occupied, S1. The scheduler
// performs no arithmetic; act_y is captured untouched. The parent ties the
// same RST to the activation unit's coefficient ROMs.
//
// Build option:
//   ACT_STATS_EN  adds stat_cnt, one saturating 16-bit completed-op counter
//                 per requester (requester i at [i*16 +: 16]).
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_x               packed signed operands, requester i at [i*WL_in +: WL_in]
//   req_mode            1 = logsig, 0 = tanh
//   req_relu            1 = ReLU (overrides mode)
//   act_x, act_modeSEL, act_ReLU_EN   registered drive to the activation unit
//   act_y               unit result (combinational from act_*)
//   rsp_valid/ready     response handshake
//   rsp_y, rsp_id       result and originating requester
// -----------------------------------------------------------------------------
module act_unit_scheduler
  import act_sched_pkg::*;
#(
  parameter  int N_REQ  = DEF_N_REQ,
  parameter  int WI_in  = DEF_WI_IN,
  parameter  int WF_in  = DEF_WF_IN,
  parameter  int WI_out = DEF_WI_OUT,
  parameter  int WF_out = DEF_WF_OUT,
  parameter  int ID_W   = $clog2(N_REQ),
  localparam int WL_in  = WI_in + WF_in,
  localparam int WL_out = WI_out + WF_out
) (
  input  logic                   CLK,
  input  logic                   RST,
  // requester side
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WL_in-1:0] req_x,
  input  logic [N_REQ-1:0]       req_mode,
  input  logic [N_REQ-1:0]       req_relu,
  // activation unit side
  output logic [WL_in-1:0]       act_x,
  output logic                   act_modeSEL,
  output logic                   act_ReLU_EN,
  input  logic [WL_out-1:0]      act_y,
  // response side
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WL_out-1:0]      rsp_y,
  output logic [ID_W-1:0]        rsp_id
`ifdef ACT_STATS_EN
  ,
  output logic [N_REQ*16-1:0]    stat_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Pipeline flow control
  // ---------------------------------------------------------------------------
  logic             adv1, adv2, accept;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;

  // S1 state
  logic [WL_in-1:0] act_x_q, act_x_d;
  act_mode_e        act_mode_q, act_mode_d;
  logic             act_relu_q, act_relu_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic             s1_valid_q, s1_valid_d;

  // S2 state
  logic [WL_out-1:0] rsp_y_q, rsp_y_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_valid_q, rsp_valid_d;

  // S2 can take new data when empty or being drained this cycle; S1 can take
  // new data when empty or when it can hand its op to S2.
  assign adv2 = !rsp_valid_q || rsp_ready;
  assign adv1 = !s1_valid_q || adv2;

  // A non-zero grant implies some req_valid is set, so accepting needs only
  // adv1 and any request.
  assign accept = adv1 && (|req_valid);

  // Ready is a function of req_valid and pipeline state only, never of the
  // operand payload. Forced low during reset so nothing is accepted.
  assign req_ready = grant & {N_REQ{adv1 && !RST}};

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req_valid),
    .adv      (adv1 && !RST),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // ---------------------------------------------------------------------------
  // Operand unpacking
  // ---------------------------------------------------------------------------
  logic [WL_in-1:0] req_x_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_x_arr[g] = req_x[g*WL_in +: WL_in];
  end

  // ---------------------------------------------------------------------------
  // S1: operand / mode register feeding the activation unit
  // ---------------------------------------------------------------------------
  always_comb begin
    act_x_d    = act_x_q;
    act_mode_d = act_mode_q;
    act_relu_d = act_relu_q;
    s1_id_d    = s1_id_q;
    s1_valid_d = s1_valid_q;
    if (adv1) begin
      if (accept) begin
        act_x_d    = req_x_arr[grant_id];
        act_mode_d = act_mode_e'(req_mode[grant_id]);
        act_relu_d = req_relu[grant_id];
        s1_id_d    = grant_id;
        s1_valid_d = 1'b1;
      end else begin
        // Bubble: drop valid but leave act_* where they were so the unit's
        // inputs do not toggle needlessly.
        s1_valid_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: response register
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    if (adv2) begin
      rsp_y_d     = act_y;
      rsp_id_d    = s1_id_q;
      rsp_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      act_x_q     <= '0;
      act_mode_q  <= MODE_TANH;
      act_relu_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_valid_q  <= 1'b0;
      rsp_y_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      act_x_q     <= act_x_d;
      act_mode_q  <= act_mode_d;
      act_relu_q  <= act_relu_d;
      s1_id_q     <= s1_id_d;
      s1_valid_q  <= s1_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign act_x       = act_x_q;
  assign act_modeSEL = act_mode_q;
  assign act_ReLU_EN = act_relu_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_valid   = rsp_valid_q;

  // ---------------------------------------------------------------------------
  // Optional per-requester completion counters
  // ---------------------------------------------------------------------------
`ifdef ACT_STATS_EN
  logic [N_REQ-1:0][15:0] stat_q, stat_d;

  // Count on the response handshake, saturating at all-ones.
  always_comb begin
    stat_d = stat_q;
    if (rsp_valid_q && rsp_ready && (stat_q[rsp_id_q] != 16'hFFFF)) begin
      stat_d[rsp_id_q] = stat_q[rsp_id_q] + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule : act_unit_scheduler
